// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: memory read port, decoder port, and control-unit
// redirect/halt signals. The fetch unit is the master; memory, decoder and
// control unit together form the slave side.
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc, halted,
        input  mem_ready, mem_rvalid, mem_rdata, instr_ready,
               redirect_valid, redirect_pc, halt_req
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, halted,
        output mem_ready, mem_rvalid, mem_rdata, instr_ready,
               redirect_valid, redirect_pc, halt_req
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order word reads, buffers returned
// instructions with their PC in a small FIFO, discards responses that belong
// to a flushed stream after a redirect, and drains to a halted state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = CW + 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q;        // address of the next request
    logic [31:0]   resp_pc_q;   // PC of the next response that will be kept
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, tail_q;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];

    logic [SW-1:0] in_flight;
    logic [SW-1:0] busy;
    logic [31:0]   redirect_target;
    logic          redirect;
    logic          req;
    logic          accept;
    logic          resp;
    logic          resp_keep;
    logic          push;
    logic          pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Handshake qualification and counter next-values for this cycle.
    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it
        // unassigned; a missing default in always_comb infers a latch.
        outstanding_d   = outstanding_q;
        discard_d       = discard_q;
        count_d         = count_q;

        in_flight       = SW'(outstanding_q) + SW'(discard_q);
        busy            = in_flight + SW'(count_q);
        redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
        redirect        = (state_q == RUN) && bus.redirect_valid;
        req             = !rst && (state_q == RUN) && !bus.redirect_valid
                          && (busy < SW'(DEPTH));
        accept          = req && bus.mem_ready;
        // A response with nothing in flight is stale (e.g. from before reset).
        resp            = bus.mem_rvalid && (in_flight != '0);
        // Responses are in order, so discards (older stream) come back first.
        resp_keep       = resp && (discard_q == '0);
        push            = resp_keep && !redirect;
        // The FIFO is frozen once halted.
        pop             = (count_q != '0) && bus.instr_ready
                          && (state_q != HALTED) && !redirect;

        if (redirect) begin
            // Everything still in flight, minus a response arriving now,
            // belongs to the flushed stream.
            outstanding_d = '0;
            discard_d     = CW'(in_flight - SW'(resp));
            count_d       = '0;
        end else begin
            if (resp && !resp_keep) begin
                discard_d = discard_q - CW'(1);
            end
            outstanding_d = outstanding_q + CW'(accept) - CW'(resp_keep);
            count_d       = count_q + CW'(push) - CW'(pop);
        end
    end

    // FSM next state: RUN -> DRAIN on halt, DRAIN -> HALTED once nothing is in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (bus.halt_req) state_d = DRAIN;
            DRAIN:   if (in_flight == '0) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Fetch PC, response PC, counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            if (redirect) begin
                pc_q      <= redirect_target;
                resp_pc_q <= redirect_target;
                head_q    <= '0;
                tail_q    <= '0;
            end else begin
                if (accept) pc_q      <= pc_q + 32'd4;
                if (push)   resp_pc_q <= resp_pc_q + 32'd4;
                if (push)   tail_q    <= next_ptr(tail_q);
                if (pop)    head_q    <= next_ptr(head_q);
            end
        end
    end

    // FIFO storage, written on each kept response.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the count gates validity,
        // so stale contents are never visible and the array stays plain RAM.
        if (push && !rst) begin
            fifo_instr[tail_q] <= bus.mem_rdata;
            fifo_pc[tail_q]    <= resp_pc_q;
        end
    end

    // Outputs: request from the issue logic, decoder view from the FIFO head.
    always_comb begin
        bus.mem_req     = req;
        bus.mem_addr    = pc_q;
        bus.instr_valid = (count_q != '0);
        bus.instr       = '0;
        bus.instr_pc    = '0;
        if (count_q != '0) begin
            bus.instr    = fifo_instr[head_q];
            bus.instr_pc = fifo_pc[head_q];
        end
        bus.halted      = (state_q == HALTED);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    logic rst_w;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if bus_w ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_w (
        .clk (clk),
        .rst (rst_w),
        .bus (bus_w)
    );

    // Reference model: fetch stream as queues of in-flight reads and buffered words.
    typedef enum {M_RUN, M_DRAIN, M_HALTED} mstate_t;
    typedef struct packed { logic [31:0] addr; logic drop; } flight_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] word; } entry_t;

    mstate_t     m_state;
    logic [31:0] m_pc;
    flight_t     m_flight[$];
    entry_t      m_fifo[$];
    logic [31:0] mem_pend[$];   // addresses the memory still owes a response for

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[5:2] + 4'd1, a[27:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_RUN;
        m_pc    = 32'h0000_0000;
        m_flight.delete();
        m_fifo.delete();
    endtask

    task automatic set_in(input bit ready, input bit give, input bit iready,
                          input bit redir, input logic [31:0] rpc, input bit halt);
        bus.mem_ready      = ready;
        bus.mem_rvalid     = give;
        bus.mem_rdata      = (give && mem_pend.size() > 0) ? mem_word(mem_pend[0]) : $urandom;
        bus.instr_ready    = iready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.halt_req       = halt;
    endtask

    // One clock cycle: compare outputs against the model, advance model and memory.
    task automatic step();
        logic    exp_req;
        bit      accept;
        bit      hit;
        int      n_before;
        flight_t f;
        #1;
        exp_req = !rst && (m_state == M_RUN) && !bus.redirect_valid
                  && (m_flight.size() + m_fifo.size() < DEPTH);
        check("mem_req", 32'(bus.mem_req), 32'(exp_req));
        check("mem_addr", bus.mem_addr, m_pc);
        check("instr_valid", 32'(bus.instr_valid), 32'(m_fifo.size() > 0));
        check("halted", 32'(bus.halted), 32'(m_state == M_HALTED));
        if (m_fifo.size() > 0) begin
            check("instr", bus.instr, m_fifo[0].word);
            check("instr_pc", bus.instr_pc, m_fifo[0].pc);
        end else if (rst) begin
            check("instr_rst", bus.instr, 32'h0);
            check("instr_pc_rst", bus.instr_pc, 32'h0);
        end

        if (bus.mem_rvalid && mem_pend.size() > 0) void'(mem_pend.pop_front());
        if (bus.mem_req && bus.mem_ready && !rst) mem_pend.push_back(bus.mem_addr);

        if (rst) begin
            model_reset();
        end else begin
            n_before = m_flight.size();
            accept   = exp_req && bus.mem_ready;
            hit      = bus.mem_rvalid && (m_flight.size() > 0);
            f        = '0;
            if (hit) f = m_flight.pop_front();
            if (m_state == M_RUN && bus.redirect_valid) begin
                m_fifo.delete();
                foreach (m_flight[i]) m_flight[i].drop = 1'b1;
                m_pc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (m_fifo.size() > 0 && bus.instr_ready && m_state != M_HALTED)
                    void'(m_fifo.pop_front());
                if (hit && !f.drop) m_fifo.push_back('{pc: f.addr, word: bus.mem_rdata});
                if (accept) begin
                    m_flight.push_back('{addr: m_pc, drop: 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
            case (m_state)
                M_RUN:   if (bus.halt_req) m_state = M_DRAIN;
                M_DRAIN: if (n_before == 0) m_state = M_HALTED;
                default: ;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_pend.delete();
        set_in(0, 0, 0, 0, 32'h0, 0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        int halted_cycles;
        rst = 1'b1;
        rst_w = 1'b1;
        set_in(0, 0, 0, 0, 32'h0, 0);
        bus_w.mem_ready = 1'b1;
        bus_w.mem_rvalid = 1'b0;
        bus_w.mem_rdata = 32'h0;
        bus_w.instr_ready = 1'b0;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc = 32'h0;
        bus_w.halt_req = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // PC wrap on the second instance, then reset mid-stream.
        rst_w = 1'b0;
        #1;
        check("wrap_req0", 32'(bus_w.mem_req), 32'h1);
        check("wrap_addr0", bus_w.mem_addr, 32'hFFFF_FFFC);
        @(posedge clk); @(negedge clk); #1;
        check("wrap_req1", 32'(bus_w.mem_req), 32'h1);
        check("wrap_addr1", bus_w.mem_addr, 32'h0000_0000);
        @(posedge clk); @(negedge clk); #1;
        check("wrap_full_req", 32'(bus_w.mem_req), 32'h0);
        check("wrap_full_addr", bus_w.mem_addr, 32'h0000_0004);
        rst_w = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        check("wrap_rst_req", 32'(bus_w.mem_req), 32'h0);
        check("wrap_rst_valid", 32'(bus_w.instr_valid), 32'h0);
        check("wrap_rst_addr", bus_w.mem_addr, 32'hFFFF_FFFC);
        rst_w = 1'b0;
        #1;
        check("wrap_restart_req", 32'(bus_w.mem_req), 32'h1);
        check("wrap_restart_addr", bus_w.mem_addr, 32'hFFFF_FFFC);
        @(posedge clk); @(negedge clk);
        rst_w = 1'b1;

        // Reset state on the main instance.
        model_reset();
        do_reset();

        // Streaming with one-cycle memory latency and an always-ready decoder.
        repeat (8) begin set_in(1, mem_pend.size() > 0, 1, 0, 32'h0, 0); step(); end

        // Backpressure: decoder stalls, FIFO fills, fetch stops at 0x8.
        do_reset();
        repeat (6) begin set_in(1, mem_pend.size() > 0, 0, 0, 32'h0, 0); step(); end
        set_in(1, mem_pend.size() > 0, 0, 0, 32'h0, 0);
        #1;
        check("bp_req", 32'(bus.mem_req), 32'h0);
        check("bp_addr", bus.mem_addr, 32'h0000_0008);
        check("bp_head_pc", bus.instr_pc, 32'h0000_0000);
        step();
        repeat (6) begin set_in(1, mem_pend.size() > 0, 1, 0, 32'h0, 0); step(); end

        // Redirect with two reads in flight.
        do_reset();
        repeat (3) begin set_in(1, 0, 1, 0, 32'h0, 0); step(); end
        set_in(1, 0, 1, 1, 32'h0000_0103, 0);
        step();
        set_in(1, 0, 1, 0, 32'h0, 0);
        #1;
        check("redir_addr", bus.mem_addr, 32'h0000_0100);
        step();
        repeat (8) begin set_in(1, mem_pend.size() > 0, 1, 0, 32'h0, 0); step(); end

        // Redirect, response and pop in the same cycle.
        do_reset();
        repeat (2) begin set_in(1, mem_pend.size() > 0, 0, 0, 32'h0, 0); step(); end
        set_in(1, 1, 1, 1, 32'h0000_0040, 0);
        step();
        set_in(1, 0, 1, 0, 32'h0, 0);
        #1;
        check("same_valid", 32'(bus.instr_valid), 32'h0);
        check("same_req", 32'(bus.mem_req), 32'h1);
        check("same_addr", bus.mem_addr, 32'h0000_0040);
        step();
        repeat (4) begin set_in(1, mem_pend.size() > 0, 1, 0, 32'h0, 0); step(); end

        // Halt with one read outstanding; later redirect must be ignored.
        do_reset();
        set_in(1, 0, 0, 0, 32'h0, 0); step();
        set_in(0, 0, 0, 0, 32'h0, 1); step();
        set_in(1, 0, 0, 0, 32'h0, 0);
        #1;
        check("halt_req_drop", 32'(bus.mem_req), 32'h0);
        step();
        set_in(0, 1, 0, 0, 32'h0, 0); step();
        set_in(0, 0, 0, 0, 32'h0, 0); step();
        set_in(1, 0, 0, 1, 32'h0000_0200, 0);
        #1;
        check("halt_halted", 32'(bus.halted), 32'h1);
        check("halt_head_pc", bus.instr_pc, 32'h0000_0000);
        step();
        repeat (2) begin set_in(1, 0, 0, 0, 32'h0, 0); step(); end
        check("halt_addr_kept", bus.mem_addr, 32'h0000_0004);

        // Reset mid-stream, then stale responses after reset.
        do_reset();
        repeat (2) begin set_in(1, 0, 1, 0, 32'h0, 0); step(); end
        rst = 1'b1;
        set_in(1, 0, 1, 0, 32'h0, 0); step();
        rst = 1'b0;
        repeat (2) begin set_in(0, 1, 1, 0, 32'h0, 0); step(); end
        mem_pend.delete();
        repeat (6) begin set_in(1, mem_pend.size() > 0, 1, 0, 32'h0, 0); step(); end

        // Random traffic.
        do_reset();
        halted_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_state == M_HALTED) halted_cycles++;
            if (halted_cycles > 4 || $urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                halted_cycles = 0;
                mem_pend.delete();
            end else begin
                rst = 1'b0;
            end
            set_in($urandom_range(0, 3) != 0,
                   (mem_pend.size() > 0 && $urandom_range(0, 2) != 0) || $urandom_range(0, 15) == 0,
                   $urandom_range(0, 2) != 0,
                   $urandom_range(0, 11) == 0,
                   $urandom,
                   $urandom_range(0, 79) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
